// File: rtl/vx_scoreboard.sv
// rtl/vx_scoreboard.sv - per-warp register busy tracking with RAW/WAW hazard gating and stall watchdog
// Issue handshake is purely combinational; only busy bits, the stall counter and deadlock are stored.
module vx_scoreboard #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int STALL_TIMEOUT = 4096,
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NR_BITS      = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ibuf_valid,
    input  logic [NW_BITS-1:0] ibuf_wid,
    input  logic               ibuf_wb,
    input  logic [NR_BITS-1:0] ibuf_rd,
    input  logic [NR_BITS-1:0] ibuf_rs1,
    input  logic [NR_BITS-1:0] ibuf_rs2,
    input  logic [NR_BITS-1:0] ibuf_rs3,
    output logic               ibuf_ready,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               wb_valid,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,
    output logic               deadlock
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(STALL_TIMEOUT);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;
    logic                               deadlock_q, deadlock_d;
    logic [NUM_REGS-1:0]                head_busy;
    logic                               wb_release;
    logic                               hazard;
    logic                               fire;

    assign wb_release = wb_valid & wb_eop;

    // Head warp's busy row with this cycle's release already applied (bypass).
    always_comb begin
        head_busy = busy_q[ibuf_wid];
        if (wb_release && (wb_wid == ibuf_wid)) begin
            head_busy[wb_rd] = 1'b0;
        end
    end

    assign hazard = head_busy[ibuf_rs1] | head_busy[ibuf_rs2] | head_busy[ibuf_rs3]
                  | (ibuf_wb & head_busy[ibuf_rd]);

    assign issue_valid = ibuf_valid & ~hazard;
    assign ibuf_ready  = issue_ready & ~hazard;
    assign fire        = issue_valid & issue_ready;
    assign deadlock    = deadlock_q;

    // Release is applied first so a same-entry set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (wb_release) begin
            busy_d[wb_wid][wb_rd] = 1'b0;
        end
        if (fire && ibuf_wb && (ibuf_rd != '0)) begin
            busy_d[ibuf_wid][ibuf_rd] = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (ibuf_valid && hazard) begin
            stall_cnt_d = (stall_cnt_q == TIMEOUT) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        deadlock_d = (stall_cnt_d == TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            deadlock_q  <= deadlock_d;
        end
    end

endmodule

// File: tb/tb_vx_scoreboard.sv
// tb/tb_vx_scoreboard.sv - directed self-checking bench for vx_scoreboard
module tb_vx_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       ibuf_valid;
    logic [1:0] ibuf_wid;
    logic       ibuf_wb;
    logic [5:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic       ibuf_ready;
    logic       issue_valid;
    logic       issue_ready;
    logic       wb_valid;
    logic [1:0] wb_wid;
    logic [5:0] wb_rd;
    logic       wb_eop;
    logic       deadlock;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_scoreboard #(
        .NUM_WARPS    (4),
        .NUM_REGS     (64),
        .STALL_TIMEOUT(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ibuf_valid (ibuf_valid),
        .ibuf_wid   (ibuf_wid),
        .ibuf_wb    (ibuf_wb),
        .ibuf_rd    (ibuf_rd),
        .ibuf_rs1   (ibuf_rs1),
        .ibuf_rs2   (ibuf_rs2),
        .ibuf_rs3   (ibuf_rs3),
        .ibuf_ready (ibuf_ready),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .wb_valid   (wb_valid),
        .wb_wid     (wb_wid),
        .wb_rd      (wb_rd),
        .wb_eop     (wb_eop),
        .deadlock   (deadlock)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic head(input logic v, input logic [1:0] w, input logic wb,
                        input logic [5:0] rd, input logic [5:0] r1,
                        input logic [5:0] r2, input logic [5:0] r3);
        ibuf_valid = v; ibuf_wid = w; ibuf_wb = wb;
        ibuf_rd = rd; ibuf_rs1 = r1; ibuf_rs2 = r2; ibuf_rs3 = r3;
        #1;
    endtask

    task automatic wback(input logic v, input logic eop, input logic [1:0] w, input logic [5:0] rd);
        wb_valid = v; wb_eop = eop; wb_wid = w; wb_rd = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; issue_ready = 1'b0;
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        chk("rst_deadlock", deadlock, 1'b0);
        chk("rst_issue_valid_idle", issue_valid, 1'b0);
        chk("rst_ibuf_ready_idle", ibuf_ready, 1'b0);
        issue_ready = 1'b1;
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        chk("rst_issue_valid", issue_valid, 1'b1);
        chk("rst_ibuf_ready", ibuf_ready, 1'b1);
        tick(); tick();
        reset = 1'b0;

        // RAW on w0 r5, released by writeback with same-cycle bypass
        head(1'b1, 2'd0, 1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        chk("w0_r5_issue", issue_valid, 1'b1);
        tick();
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0);
        chk("raw_r5_stall", issue_valid, 1'b0);
        chk("raw_r5_ibuf_ready", ibuf_ready, 1'b0);
        wback(1'b1, 1'b0, 2'd0, 6'd5);
        chk("wb_no_eop_stall", issue_valid, 1'b0);
        wback(1'b1, 1'b1, 2'd0, 6'd5);
        chk("wb_bypass_issue", issue_valid, 1'b1);
        chk("wb_bypass_ready", ibuf_ready, 1'b1);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        chk("r5_released", issue_valid, 1'b1);

        // r0 is never tracked
        head(1'b1, 2'd0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        chk("r0_rs1_issue", issue_valid, 1'b1);
        head(1'b1, 2'd0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
        chk("r0_waw_issue", issue_valid, 1'b1);

        // warp independence and WAW on w1 r7
        head(1'b1, 2'd1, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd0, 6'd7, 6'd0);
        chk("w0_rs2_7_indep", issue_valid, 1'b1);
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd0, 6'd7, 6'd0);
        chk("w1_rs2_7_raw", issue_valid, 1'b0);
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd7);
        chk("w1_rs3_7_raw", issue_valid, 1'b0);
        head(1'b1, 2'd1, 1'b1, 6'd7, 6'd0, 6'd0, 6'd0);
        chk("w1_waw_7", issue_valid, 1'b0);
        head(1'b1, 2'd1, 1'b0, 6'd7, 6'd0, 6'd0, 6'd0);
        chk("w1_rd7_nowb", issue_valid, 1'b1);

        // backpressure without hazard
        issue_ready = 1'b0;
        head(1'b1, 2'd0, 1'b1, 6'd12, 6'd0, 6'd0, 6'd0);
        chk("bp_issue_valid", issue_valid, 1'b1);
        chk("bp_ibuf_ready", ibuf_ready, 1'b0);
        repeat (10) tick();
        chk("bp_no_deadlock", deadlock, 1'b0);
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd12, 6'd0, 6'd0);
        chk("bp_no_set", issue_valid, 1'b1);
        issue_ready = 1'b1;

        // set w2 r9, then release+set same entry: set wins
        head(1'b1, 2'd2, 1'b1, 6'd9, 6'd0, 6'd0, 6'd0);
        tick();
        wback(1'b1, 1'b1, 2'd2, 6'd9);
        chk("same_entry_fire", issue_valid, 1'b1);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        head(1'b1, 2'd2, 1'b0, 6'd0, 6'd9, 6'd0, 6'd0);
        chk("set_wins_stall", issue_valid, 1'b0);

        // release w1 r7 and set w3 r11 in one cycle
        head(1'b1, 2'd3, 1'b1, 6'd11, 6'd0, 6'd0, 6'd0);
        wback(1'b1, 1'b1, 2'd1, 6'd7);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd11, 6'd0, 6'd0);
        chk("diff_set_w3_11", issue_valid, 1'b0);
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd7, 6'd0, 6'd0);
        chk("diff_rel_w1_7", issue_valid, 1'b1);

        // releasing an idle entry changes nothing
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wback(1'b1, 1'b1, 2'd0, 6'd20);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd20, 6'd0, 6'd0);
        chk("noop_rel_r20", issue_valid, 1'b1);
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd11, 6'd0, 6'd0);
        chk("noop_keeps_w3_11", issue_valid, 1'b0);
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();

        // deadlock after 8 hazard-stall cycles
        head(1'b1, 2'd3, 1'b0, 6'd0, 6'd11, 6'd0, 6'd0);
        repeat (7) tick();
        chk("dl_after7", deadlock, 1'b0);
        tick();
        chk("dl_after8", deadlock, 1'b1);
        repeat (3) tick();
        chk("dl_saturated", deadlock, 1'b1);
        wback(1'b1, 1'b1, 2'd3, 6'd11);
        chk("dl_rel_issue", issue_valid, 1'b1);
        chk("dl_held_rel_cycle", deadlock, 1'b1);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        chk("dl_cleared", deadlock, 1'b0);

        // async reset mid-stall with several busy bits
        head(1'b1, 2'd0, 1'b1, 6'd3, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd1, 1'b1, 6'd4, 6'd0, 6'd0, 6'd0);
        tick();
        head(1'b1, 2'd0, 1'b0, 6'd0, 6'd3, 6'd0, 6'd0);
        repeat (9) tick();
        chk("pre_rst_deadlock", deadlock, 1'b1);
        chk("pre_rst_stall", issue_valid, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_deadlock", deadlock, 1'b0);
        chk("arst_w0_r3", issue_valid, 1'b1);
        head(1'b1, 2'd1, 1'b0, 6'd0, 6'd4, 6'd0, 6'd0);
        chk("arst_w1_r4", issue_valid, 1'b1);
        head(1'b1, 2'd2, 1'b0, 6'd0, 6'd9, 6'd0, 6'd0);
        chk("arst_w2_r9", issue_valid, 1'b1);
        tick();
        reset = 1'b0;

        // stale writeback after reset is harmless
        head(1'b0, 2'd0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wback(1'b1, 1'b1, 2'd1, 6'd4);
        tick();
        wback(1'b0, 1'b0, 2'd0, 6'd0);
        head(1'b1, 2'd1, 1'b1, 6'd4, 6'd4, 6'd0, 6'd0);
        chk("post_rst_w1_r4", issue_valid, 1'b1);
        chk("post_rst_deadlock", deadlock, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
